// File: rtl/scratchpad_mem.sv
// rtl/scratchpad_mem.sv - dual-port fetch/load-store scratchpad with fixed response latency
module scratchpad_mem #(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req_valid,
    output logic        imem_req_ready,
    input  logic [31:0] imem_req_addr,
    output logic        imem_resp_valid,
    output logic [31:0] imem_resp_data,
    output logic        imem_resp_err,
    input  logic        dmem_req_valid,
    output logic        dmem_req_ready,
    input  logic [31:0] dmem_req_addr,
    input  logic [31:0] dmem_req_data,
    input  logic        dmem_req_fcn,
    input  logic [2:0]  dmem_req_typ,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_resp_data,
    output logic        dmem_resp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- fetch port decode ----------------
    logic [31:0]   i_off;
    logic          i_err;
    logic [AW-1:0] i_idx;
    logic [31:0]   i_result;

    assign i_off    = imem_req_addr - BASE_ADDR;
    assign i_idx    = i_off[AW+1:2];
    assign i_err    = !({1'b0, i_off} < SPAN) || (imem_req_addr[1:0] != 2'b00);
    assign i_result = i_err ? 32'h0 : mem[i_idx];

    // ---------------- data port decode ----------------
    logic [31:0]   d_off;
    logic [AW-1:0] d_idx;
    logic [31:0]   d_word;
    logic [1:0]    d_a;
    logic          d_legal;
    logic          d_misal;
    logic          d_err;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata;
    logic [7:0]    d_byte;
    logic [15:0]   d_half;
    logic [31:0]   d_ext;
    logic [31:0]   d_result;

    assign d_off  = dmem_req_addr - BASE_ADDR;
    assign d_idx  = d_off[AW+1:2];
    assign d_word = mem[d_idx];
    assign d_a    = dmem_req_addr[1:0];

    // Lane selection, extension, alignment and byte enables by access type
    always_comb begin
        d_legal = 1'b1;
        d_misal = 1'b0;
        d_be    = 4'b0000;
        d_wdata = 32'h0;
        d_ext   = 32'h0;
        case (d_a)
            2'd0:    d_byte = d_word[7:0];
            2'd1:    d_byte = d_word[15:8];
            2'd2:    d_byte = d_word[23:16];
            default: d_byte = d_word[31:24];
        endcase
        d_half = d_a[1] ? d_word[31:16] : d_word[15:0];
        case (dmem_req_typ)
            MT_B, MT_BU: begin
                d_be    = 4'b0001 << d_a;
                d_wdata = {4{dmem_req_data[7:0]}};
                d_ext   = (dmem_req_typ == MT_B) ? {{24{d_byte[7]}}, d_byte} : {24'h0, d_byte};
            end
            MT_H, MT_HU: begin
                d_misal = d_a[0];
                d_be    = d_a[1] ? 4'b1100 : 4'b0011;
                d_wdata = {2{dmem_req_data[15:0]}};
                d_ext   = (dmem_req_typ == MT_H) ? {{16{d_half[15]}}, d_half} : {16'h0, d_half};
            end
            MT_W: begin
                d_misal = (d_a != 2'b00);
                d_be    = 4'b1111;
                d_wdata = dmem_req_data;
                d_ext   = d_word;
            end
            default: d_legal = 1'b0;
        endcase
        d_err    = !d_legal || d_misal || !({1'b0, d_off} < SPAN);
        d_result = (d_err || dmem_req_fcn) ? 32'h0 : d_ext;
    end

    // ---------------- per-port FSMs ----------------
    state_t     i_state, i_state_nxt;
    state_t     d_state, d_state_nxt;
    logic [1:0] i_cnt, d_cnt;
    logic       i_fire, d_fire;
    logic       i_load, d_load;
    logic [31:0] i_pend_data, d_pend_data;
    logic        i_pend_err, d_pend_err;

    // State registers; reset drops any request in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_state <= S_IDLE;
            d_state <= S_IDLE;
        end else begin
            i_state <= i_state_nxt;
            d_state <= d_state_nxt;
        end
    end

    // Fetch port next state; i_load marks the edge that launches the response
    always_comb begin
        i_state_nxt    = i_state;
        imem_req_ready = 1'b0;
        i_fire         = 1'b0;
        i_load         = 1'b0;
        case (i_state)
            S_IDLE: begin
                imem_req_ready = 1'b1;
                if (imem_req_valid) begin
                    i_fire      = 1'b1;
                    i_load      = (LATENCY == 1);
                    i_state_nxt = S_BUSY;
                end
            end
            default: begin
                i_load = (i_cnt == 2'd1);
                if (i_cnt == 2'd0) i_state_nxt = S_IDLE;
            end
        endcase
    end

    // Data port next state; same sequencing as the fetch port
    always_comb begin
        d_state_nxt    = d_state;
        dmem_req_ready = 1'b0;
        d_fire         = 1'b0;
        d_load         = 1'b0;
        case (d_state)
            S_IDLE: begin
                dmem_req_ready = 1'b1;
                if (dmem_req_valid) begin
                    d_fire      = 1'b1;
                    d_load      = (LATENCY == 1);
                    d_state_nxt = S_BUSY;
                end
            end
            default: begin
                d_load = (d_cnt == 2'd1);
                if (d_cnt == 2'd0) d_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fetch response pipeline: capture at accept, present for one cycle at the end
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_cnt           <= 2'd0;
            i_pend_data     <= 32'h0;
            i_pend_err      <= 1'b0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= 32'h0;
            imem_resp_err   <= 1'b0;
        end else begin
            imem_resp_valid <= i_load;
            if (i_fire) begin
                i_cnt       <= CNT_INIT;
                i_pend_data <= i_result;
                i_pend_err  <= i_err;
            end else if (i_state == S_BUSY && i_cnt != 2'd0) begin
                i_cnt <= i_cnt - 2'd1;
            end
            if (i_load) begin
                imem_resp_data <= i_fire ? i_result : i_pend_data;
                imem_resp_err  <= i_fire ? i_err : i_pend_err;
            end
        end
    end

    // Data response pipeline: same shape as the fetch side
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_cnt           <= 2'd0;
            d_pend_data     <= 32'h0;
            d_pend_err      <= 1'b0;
            dmem_resp_valid <= 1'b0;
            dmem_resp_data  <= 32'h0;
            dmem_resp_err   <= 1'b0;
        end else begin
            dmem_resp_valid <= d_load;
            if (d_fire) begin
                d_cnt       <= CNT_INIT;
                d_pend_data <= d_result;
                d_pend_err  <= d_err;
            end else if (d_state == S_BUSY && d_cnt != 2'd0) begin
                d_cnt <= d_cnt - 2'd1;
            end
            if (d_load) begin
                dmem_resp_data <= d_fire ? d_result : d_pend_data;
                dmem_resp_err  <= d_fire ? d_err : d_pend_err;
            end
        end
    end

    // Byte-masked store at the accept edge; fetch reads above see the pre-write word
    always_ff @(posedge clk) begin
        if (rst && d_fire && dmem_req_fcn && !d_err) begin
            for (int i = 0; i < 4; i++) begin
                if (d_be[i]) mem[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_scratchpad_mem.sv
// tb/tb_scratchpad_mem.sv - directed and randomized checks of scratchpad_mem against a word/byte model
module tb_scratchpad_mem;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] SPAN  = 32'h0001_0000;
    localparam logic [31:0] BASE3 = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        i_valid, i_ready, i_rv, i_re;
    logic [31:0] i_addr, i_rd;
    logic        d_valid, d_ready, d_fcn, d_rv, d_re;
    logic [2:0]  d_typ;
    logic [31:0] d_addr, d_wdata, d_rd;

    logic        i3_valid, i3_ready, i3_rv, i3_re;
    logic [31:0] i3_addr, i3_rd;
    logic        d3_valid, d3_ready, d3_fcn, d3_rv, d3_re;
    logic [2:0]  d3_typ;
    logic [31:0] d3_addr, d3_wdata, d3_rd;

    scratchpad_mem u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(i_valid), .imem_req_ready(i_ready), .imem_req_addr(i_addr),
        .imem_resp_valid(i_rv), .imem_resp_data(i_rd), .imem_resp_err(i_re),
        .dmem_req_valid(d_valid), .dmem_req_ready(d_ready), .dmem_req_addr(d_addr),
        .dmem_req_data(d_wdata), .dmem_req_fcn(d_fcn), .dmem_req_typ(d_typ),
        .dmem_resp_valid(d_rv), .dmem_resp_data(d_rd), .dmem_resp_err(d_re)
    );

    scratchpad_mem #(.DEPTH_WORDS(256), .BASE_ADDR(BASE3), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .imem_req_valid(i3_valid), .imem_req_ready(i3_ready), .imem_req_addr(i3_addr),
        .imem_resp_valid(i3_rv), .imem_resp_data(i3_rd), .imem_resp_err(i3_re),
        .dmem_req_valid(d3_valid), .dmem_req_ready(d3_ready), .dmem_req_addr(d3_addr),
        .dmem_req_data(d3_wdata), .dmem_req_fcn(d3_fcn), .dmem_req_typ(d3_typ),
        .dmem_resp_valid(d3_rv), .dmem_resp_data(d3_rd), .dmem_resp_err(d3_re)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic int unsigned acc_size(input logic [2:0] typ);
        if (typ == 3'd3) return 4;
        if (typ == 3'd2 || typ == 3'd6) return 2;
        return 1;
    endfunction

    function automatic bit model_err(input logic [31:0] addr, input logic [2:0] typ);
        logic [31:0] off;
        if (!(typ inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6})) return 1'b1;
        if (addr % acc_size(typ) != 0) return 1'b1;
        off = addr - BASE;
        return off >= SPAN;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] typ);
        int unsigned bits;
        logic [31:0] v;
        if (typ == 3'd3) return word;
        bits = 8 * acc_size(typ);
        v = (word >> (8 * (addr % 4))) & ((32'h1 << bits) - 32'h1);
        if ((typ == 3'd1 || typ == 3'd2) && v >= (32'h1 << (bits - 1)))
            v = v - (32'h1 << bits);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] data);
        logic [31:0] w;
        int unsigned p;
        w = ref_mem[widx(addr)];
        for (int i = 0; i < int'(acc_size(typ)); i++) begin
            p = 8 * ((addr % 4) + i);
            w = (w & ~(32'hFF << p)) | (((data >> (8 * i)) & 32'hFF) << p);
        end
        ref_mem[widx(addr)] = w;
    endtask

    // One transaction on the LATENCY=1 instance, optionally on both ports in the same edge
    task automatic xact(input bit iv, input logic [31:0] ia, input bit dv, input bit fcn,
                        input logic [2:0] typ, input logic [31:0] da, input logic [31:0] dd,
                        input string tag);
        logic [31:0] i_exp, d_exp;
        bit i_eerr, d_eerr;
        i_eerr = model_err(ia, 3'd3);
        i_exp  = 32'h0;
        if (!i_eerr) i_exp = ref_mem[widx(ia)];
        d_eerr = model_err(da, typ);
        d_exp  = 32'h0;
        if (!d_eerr && !fcn) d_exp = model_load(ref_mem[widx(da)], da, typ);
        if (dv && fcn && !d_eerr) model_store(da, typ, dd);

        @(negedge clk);
        check({tag, ".i_ready_pre"}, 32'(i_ready), 32'd1);
        check({tag, ".d_ready_pre"}, 32'(d_ready), 32'd1);
        i_valid = iv; i_addr = ia;
        d_valid = dv; d_addr = da; d_fcn = fcn; d_typ = typ; d_wdata = dd;
        @(negedge clk);
        i_valid = 1'b0; d_valid = 1'b0;
        check({tag, ".i_rv"}, 32'(i_rv), 32'(iv));
        check({tag, ".d_rv"}, 32'(d_rv), 32'(dv));
        check({tag, ".i_ready_busy"}, 32'(i_ready), 32'(!iv));
        check({tag, ".d_ready_busy"}, 32'(d_ready), 32'(!dv));
        if (iv) begin
            check({tag, ".i_data"}, i_rd, i_exp);
            check({tag, ".i_err"}, 32'(i_re), 32'(i_eerr));
        end
        if (dv) begin
            check({tag, ".d_data"}, d_rd, d_exp);
            check({tag, ".d_err"}, 32'(d_re), 32'(d_eerr));
        end
        @(negedge clk);
        check({tag, ".i_rv_off"}, 32'(i_rv), 32'd0);
        check({tag, ".d_rv_off"}, 32'(d_rv), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h0001_0000 + 32'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: return 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        int k3_lat_i, k3_lat_d;
        rst = 1'b0;
        i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_wdata = 0; d_fcn = 0; d_typ = 0;
        i3_valid = 0; i3_addr = 0; d3_valid = 0; d3_addr = 0; d3_wdata = 0; d3_fcn = 0; d3_typ = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.i_ready", 32'(i_ready), 32'd1);
        check("rst.d_ready", 32'(d_ready), 32'd1);
        check("rst.i_rv", 32'(i_rv), 32'd0);
        check("rst.d_rv", 32'(d_rv), 32'd0);
        check("rst.i_data", i_rd, 32'h0);
        check("rst.d_data", d_rd, 32'h0);
        check("rst.i_err", 32'(i_re), 32'd0);
        check("rst.d_err", 32'(d_re), 32'd0);
        check("rst.i3_ready", 32'(i3_ready), 32'd1);
        rst = 1'b1;

        // Known contents for the exercised window
        for (int w = 0; w < 256; w++) xact(0, 0, 1, 1, 3'd3, 32'(w * 4), 32'h0, "init");

        // Word store/load, lane loads, byte store
        xact(0, 0, 1, 1, 3'd3, 32'h100, 32'hDEADBEEF, "t1.st");
        xact(0, 0, 1, 0, 3'd3, 32'h100, 0, "t1.ld");
        xact(0, 0, 1, 0, 3'd1, 32'h103, 0, "t2.b");
        xact(0, 0, 1, 0, 3'd5, 32'h103, 0, "t2.bu");
        xact(0, 0, 1, 0, 3'd2, 32'h100, 0, "t2.h");
        xact(0, 0, 1, 0, 3'd6, 32'h102, 0, "t2.hu");
        xact(0, 0, 1, 1, 3'd1, 32'h101, 32'hAAAA_AA55, "t3.st");
        xact(0, 0, 1, 0, 3'd3, 32'h100, 0, "t3.ld");
        check("t3.model", ref_mem[widx(32'h100)], 32'hDEAD55EF);

        // Erroring accesses, including stores that must not write
        xact(0, 0, 1, 0, 3'd3, 32'h102, 0, "t4.w_mis");
        xact(0, 0, 1, 0, 3'd2, 32'h101, 0, "t4.h_mis");
        xact(1, 32'h106, 0, 0, 0, 0, 0, "t4.fetch_mis");
        xact(0, 0, 1, 0, 3'd3, BASE + SPAN, 0, "t4.oor");
        xact(0, 0, 1, 1, 3'd3, 32'h102, 32'h1111_1111, "t4.st_mis");
        xact(0, 0, 1, 1, 3'd0, 32'h100, 32'h2222_2222, "t4.st_typ");
        xact(0, 0, 1, 1, 3'd3, BASE + SPAN, 32'h3333_3333, "t4.st_oor");
        xact(0, 0, 1, 0, 3'd3, 32'h100, 0, "t4.unchanged");
        xact(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, "t4.fetch_wrap");

        // Read-before-write on a shared edge
        xact(1, 32'h200, 1, 1, 3'd3, 32'h200, 32'h12345678, "t5.same");
        xact(1, 32'h200, 0, 0, 0, 0, 0, "t5.next");

        // Randomized mix on both ports
        for (int n = 0; n < 400; n++) begin
            xact(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_addr(), $urandom(), "rnd");
        end

        // LATENCY=3 instance: out-of-range on both ports, latency of the error response
        @(negedge clk);
        i3_valid = 1; i3_addr = 32'h0000_0FFC;
        d3_valid = 1; d3_addr = 32'h0000_1400; d3_fcn = 0; d3_typ = 3'd3;
        k3_lat_i = 0; k3_lat_d = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            i3_valid = 0; d3_valid = 0;
            if (i3_rv) begin
                k3_lat_i = k;
                check("l3.i_err", 32'(i3_re), 32'd1);
                check("l3.i_data", i3_rd, 32'h0);
            end
            if (d3_rv) begin
                k3_lat_d = k;
                check("l3.d_err", 32'(d3_re), 32'd1);
                check("l3.d_data", d3_rd, 32'h0);
            end
        end
        check("l3.i_lat", 32'(k3_lat_i), 32'd3);
        check("l3.d_lat", 32'(k3_lat_d), 32'd3);

        // Request held valid: accepts every 4 cycles, pulse in the last busy cycle
        i3_addr = BASE3;
        i3_valid = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("l3.ready_k%0d", k), 32'(i3_ready), 32'(k % 4 == 0));
            check($sformatf("l3.rv_k%0d", k), 32'(i3_rv), 32'(k % 4 == 3));
        end
        @(negedge clk);
        check("l3.busy_before_rst", 32'(i3_ready), 32'd0);
        rst = 1'b0; i3_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        check("l3.rst_ready", 32'(i3_ready), 32'd1);
        check("l3.rst_rv", 32'(i3_rv), 32'd0);
        check("l3.rst_data", i3_rd, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("l3.no_resp", 32'(i3_rv), 32'd0);
            check("l3.ready_idle", 32'(i3_ready), 32'd1);
        end

        // Memory contents survive reset
        xact(1, 32'h200, 1, 0, 3'd3, 32'h100, 0, "retain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
